// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round constants, key-schedule FSM states and word helpers.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  // Index r selects the constant for round r (1..10).
  localparam logic [1:NUM_ROUNDS][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_READY
  } ks_state_e;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry 0 sits in the most significant byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes_dec_key_sched.sv
// AES-128 key expansion (one round per cycle) serving round keys 10 down to 0 on request.
module aes_dec_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         vin,
  input  logic         key_req,
  output logic         busy,
  output logic         ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         vout,
  output logic         last
);

  ks_state_e    state, state_n;
  logic [3:0]   r, p;
  logic [127:0] rk [0:NUM_ROUNDS];
  logic [127:0] wk, nxt;
  logic [31:0]  rot, sub, w0, w1, w2, w3;
  logic         load, step, serve;

  assign load  = vin && (state != S_EXPAND);
  assign step  = (state == S_EXPAND);
  assign serve = (state == S_READY) && key_req && !vin;
  assign busy  = step;
  assign ready = (state == S_READY);

  // wk holds the most recently produced key, so the next round never needs rk[r-1].
  assign rot = rot_word(wk[31:0]);
  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end

  assign w0  = wk[127:96] ^ sub ^ {RCON[r], 24'h0};
  assign w1  = wk[95:64] ^ w0;
  assign w2  = wk[63:32] ^ w1;
  assign w3  = wk[31:0] ^ w2;
  assign nxt = {w0, w1, w2, w3};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (vin) state_n = S_EXPAND;
      S_EXPAND: if (r == LAST_RND) state_n = S_READY;
      S_READY:  if (vin) state_n = S_EXPAND;
      default:  state_n = S_IDLE;
    endcase
  end

  // Schedule storage carries no reset; it is only read once a full expansion completes.
  always_ff @(posedge clk) begin
    if (load) begin
      rk[0] <= key_in;
      wk    <= key_in;
    end else if (step) begin
      rk[r] <= nxt;
      wk    <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r         <= '0;
      p         <= LAST_RND;
      vout      <= 1'b0;
      last      <= 1'b0;
      round_key <= '0;
      round_idx <= '0;
    end else begin
      vout <= serve;
      last <= serve && (p == 4'd0);
      if (load)      r <= 4'd1;
      else if (step) r <= (r == LAST_RND) ? 4'd0 : r + 4'd1;
      if (step && r == LAST_RND) begin
        p <= LAST_RND;
      end else if (serve) begin
        round_key <= rk[p];
        round_idx <= p;
        p         <= (p == 4'd0) ? LAST_RND : p - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Randomized bench for aes_dec_key_sched against a whole-schedule reference model.
module tb_aes_dec_key_sched;

  typedef logic [127:0] sched_t [0:10];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vin = 1'b0;
  logic         key_req = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, ready, vout, last;
  logic [127:0] round_key;
  logic [3:0]   round_idx;

  int total = 0;
  int bad = 0;

  aes_dec_key_sched dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .vin(vin), .key_req(key_req),
    .busy(busy), .ready(ready), .round_key(round_key), .round_idx(round_idx),
    .vout(vout), .last(last)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) acc = acc ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then affine map.
  task automatic init_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic sched_t expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) s[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return s;
  endfunction

  sched_t       m_sched;
  int           m_left = 0;
  int           m_p = 10;
  logic         m_valid = 1'b0;
  logic         m_vout = 1'b0;
  logic         m_last = 1'b0;
  logic [3:0]   m_idx = '0;
  logic [127:0] m_key = '0;
  logic         chk_on = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_valid = 1'b0; m_p = 10;
      m_vout = 1'b0; m_last = 1'b0; m_idx = '0; m_key = '0;
      chk_on = 1'b1;
    end else begin
      m_vout = 1'b0;
      m_last = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1'b1;
          m_p = 10;
        end
      end else if (vin) begin
        m_sched = expand(key_in);
        m_left = 10;
        m_valid = 1'b0;
      end else if (m_valid && key_req) begin
        m_vout = 1'b1;
        m_key  = m_sched[m_p];
        m_idx  = 4'(m_p);
        m_last = (m_p == 0);
        m_p    = (m_p == 0) ? 10 : m_p - 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [135:0] act, exp;
      act = {busy, ready, vout, last, round_idx, round_key};
      exp = {m_left > 0, m_valid && m_left == 0, m_vout, m_last, m_idx, m_key};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got=%h expected=%h", $time, act, exp);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!ready && n < 30) begin
      tick();
      n++;
    end
    chk(nm, 128'(ready), 128'd1);
  endtask

  initial begin
    sched_t s;
    init_sbox();
    chk("pin_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("pin_sbox_53", 128'(sb[8'h53]), 128'hed);
    s = expand(K_FIPS);
    chk("pin_fips_k10", s[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("pin_fips_k9",  s[9],  128'hac7766f319fadc2128d12941575c006e);
    chk("pin_fips_k1",  s[1],  128'ha0fafe1788542cb123a339392a6c7605);
    s = expand(K_SEQ);
    chk("pin_seq_k10",  s[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // reset state, then requests with no schedule
    repeat (3) tick();
    chk("reset_outs", {124'(0), busy, ready, vout, last}, '0);
    chk("reset_key", round_key, '0);
    rst_n = 1'b1;
    key_req = 1'b1;
    repeat (3) tick();
    chk("req_unready_vout", 128'(vout), '0);
    chk("req_unready_key", round_key, '0);
    key_req = 1'b0;

    // FIPS key; vin/key_req noise during expansion must be ignored
    key_in = K_FIPS; vin = 1'b1;
    tick();
    vin = 1'b0;
    chk("busy_after_load", 128'(busy), 128'd1);
    key_in = K_SEQ; vin = 1'b1; key_req = 1'b1;
    repeat (3) tick();
    chk("expand_no_vout", 128'(vout), '0);
    vin = 1'b0; key_req = 1'b0;
    wait_ready("ready_fips");

    key_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("serve_idx_%0d", i), 128'(round_idx), 128'((i == 11) ? 10 : 10 - i));
      if (i == 0)  chk("serve_k10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      if (i == 1)  chk("serve_k9",  round_key, 128'hac7766f319fadc2128d12941575c006e);
      if (i == 9)  chk("serve_k1",  round_key, 128'ha0fafe1788542cb123a339392a6c7605);
      if (i == 10) chk("serve_k0",  round_key, K_FIPS);
      chk($sformatf("serve_last_%0d", i), 128'(last), 128'(i == 10));
    end
    repeat (4) tick();
    // p is now 5: new key plus simultaneous request
    key_in = K_SEQ; vin = 1'b1;
    tick();
    vin = 1'b0; key_req = 1'b0;
    chk("vin_prio_vout", 128'(vout), '0);
    chk("vin_prio_busy", 128'(busy), 128'd1);
    wait_ready("ready_seq");
    key_req = 1'b1;
    tick();
    key_req = 1'b0;
    chk("seq_k10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("seq_idx", 128'(round_idx), 128'd10);

    // reset in the middle of an expansion
    key_in = {$urandom, $urandom, $urandom, $urandom}; vin = 1'b1;
    tick();
    vin = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_outs", {124'(0), busy, ready, vout, last}, '0);
    chk("midrst_key", {120'(0), round_idx, 4'(0)} | round_key, '0);
    rst_n = 1'b1; key_req = 1'b1;
    repeat (15) tick();
    chk("midrst_ready", 128'(ready), '0);
    chk("midrst_vout", 128'(vout), '0);
    key_req = 1'b0;

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      vin     = ($urandom % 16) == 0;
      key_in  = {$urandom, $urandom, $urandom, $urandom};
      key_req = $urandom % 2;
      rst_n   = ($urandom % 500) != 0;
      tick();
    end
    vin = 1'b0; key_req = 1'b0; rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
